// File: rtl/vecfetch.sv
// Interrupt-vector fetch sequencer sharing the $10-$1F register bus with the CPU.
// Fetches the vector bytes for the highest-priority pending source and holds them until acknowledged.
module vecfetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  cpu_AD,
  input  logic [7:0]  cpu_DI,
  output logic [7:0]  cpu_DO,
  input  logic        cpu_rw,
  input  logic        cpu_cs,
  output logic        cpu_wait,
  output logic [4:0]  ps_AD,
  output logic [7:0]  ps_DI,
  input  logic [7:0]  ps_DO,
  output logic        ps_rw,
  output logic        ps_cs,
  input  logic        req_irq,
  input  logic        req_swi,
  input  logic        req_nmi,
  input  logic        req_res,
  output logic [3:0]  pend,
  output logic        vec_valid,
  output logic [31:0] vec_addr,
  output logic [1:0]  vec_src,
  input  logic        vec_ack
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_VALID} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  src_q, src_d;
  logic [31:0] addr_q, addr_d;
  logic        issued_q, issued_d;
  logic [3:0]  req;
  logic [1:0]  sel;

  assign req = {req_res, req_nmi, req_swi, req_irq};

  function automatic logic [4:0] vbase(input logic [1:0] s);
    case (s)
      2'd0:    vbase = 5'h12;
      2'd1:    vbase = 5'h15;
      2'd2:    vbase = 5'h19;
      default: vbase = 5'h1D;
    endcase
  endfunction

  // Index of the final byte: SWI/NMI are 4-byte vectors, IRQ/RES 3-byte.
  function automatic logic [1:0] vlast(input logic [1:0] s);
    vlast = (s == 2'd1 || s == 2'd2) ? 2'd3 : 2'd2;
  endfunction

  always_comb begin
    sel = 2'd0;
    if      (pend_q[3]) sel = 2'd3;
    else if (pend_q[2]) sel = 2'd2;
    else if (pend_q[1]) sel = 2'd1;
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    k_d      = k_q;
    src_d    = src_q;
    addr_d   = addr_q;
    issued_d = 1'b0;
    ps_AD    = cpu_AD;
    ps_rw    = cpu_rw;
    ps_cs    = cpu_cs;
    cpu_wait = 1'b0;
    // ps_DO is registered, so a byte lands one cycle after its read was issued.
    if (issued_q) addr_d = {addr_q[23:0], ps_DO};
    case (state_q)
      S_IDLE: begin
        if (pend_q != 4'd0 && !cpu_cs) begin
          src_d   = sel;
          addr_d  = 32'd0;
          k_d     = 2'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ps_AD    = vbase(src_q) + {3'b000, k_q};
        ps_rw    = 1'b1;
        ps_cs    = 1'b1;
        cpu_wait = cpu_cs;
        issued_d = 1'b1;
        if (k_q == vlast(src_q)) state_d = S_LAST;
        else                     k_d = k_q + 2'd1;
      end
      S_LAST: begin
        ps_rw    = 1'b1;
        ps_cs    = 1'b0;
        cpu_wait = cpu_cs;
        state_d  = S_VALID;
      end
      default: begin
        if (vec_ack) begin
          pend_d[src_q] = 1'b0;
          state_d       = S_IDLE;
        end
      end
    endcase
    // A new pulse overrides a same-cycle ack clear.
    pend_d = pend_d | req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pend_q   <= 4'd0;
      k_q      <= 2'd0;
      src_q    <= 2'd0;
      addr_q   <= 32'd0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      k_q      <= k_d;
      src_q    <= src_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
    end
  end

  assign cpu_DO    = ps_DO;
  assign ps_DI     = cpu_DI;
  assign pend      = pend_q;
  assign vec_valid = (state_q == S_VALID);
  assign vec_addr  = addr_q;
  assign vec_src   = src_q;

endmodule

// File: tb/tb_vecfetch.sv
// Scoreboard bench for vecfetch: a register-block model behind ps_*, directed scenarios,
// and a monitor that checks every vec_valid rise against queued expectations.
module tb_vecfetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  cpu_AD = 5'h00;
  logic [7:0]  cpu_DI = 8'h00;
  logic [7:0]  cpu_DO;
  logic        cpu_rw = 1'b1;
  logic        cpu_cs = 1'b0;
  logic        cpu_wait;
  logic [4:0]  ps_AD;
  logic [7:0]  ps_DI;
  logic [7:0]  ps_DO;
  logic        ps_rw, ps_cs;
  logic [3:0]  reqv = 4'd0;
  logic [3:0]  pend;
  logic        vec_valid;
  logic [31:0] vec_addr;
  logic [1:0]  vec_src;
  logic        vec_ack = 1'b0;

  vecfetch dut (
    .clk(clk), .rst(rst),
    .cpu_AD(cpu_AD), .cpu_DI(cpu_DI), .cpu_DO(cpu_DO), .cpu_rw(cpu_rw),
    .cpu_cs(cpu_cs), .cpu_wait(cpu_wait),
    .ps_AD(ps_AD), .ps_DI(ps_DI), .ps_DO(ps_DO), .ps_rw(ps_rw), .ps_cs(ps_cs),
    .req_irq(reqv[0]), .req_swi(reqv[1]), .req_nmi(reqv[2]), .req_res(reqv[3]),
    .pend(pend), .vec_valid(vec_valid), .vec_addr(vec_addr), .vec_src(vec_src),
    .vec_ack(vec_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register block: read data registered, valid the cycle after a read select.
  logic [7:0] mem [32];
  always @(posedge clk)
    if (ps_cs) begin
      if (!ps_rw) mem[ps_AD] <= ps_DI;
      else        ps_DO <= mem[ps_AD];
    end

  typedef struct {
    logic [1:0]  src;
    logic [31:0] addr;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising vec_valid must match the oldest expected vector.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst && vec_valid && !prev_v) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: vec_addr %h vec_src %0d at cycle %0d", vec_addr, vec_src, cyc);
      end else begin
        e = sb.pop_front();
        check("vec_addr", vec_addr, e.addr);
        check("vec_src", {30'd0, vec_src}, {30'd0, e.src});
        check("vec_cycle", cyc, e.cyc);
      end
    end
    prev_v = vec_valid;
  end

  function automatic logic [4:0] base_of(input int s);
    case (s)
      0: base_of = 5'h12;
      1: base_of = 5'h15;
      2: base_of = 5'h19;
      default: base_of = 5'h1D;
    endcase
  endfunction

  function automatic int n_of(input int s);
    n_of = (s == 1 || s == 2) ? 4 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [4:0] a, input logic [7:0] d);
    cpu_AD = a; cpu_DI = d; cpu_rw = 1'b0; cpu_cs = 1'b1;
    tick();
    cpu_cs = 1'b0; cpu_rw = 1'b1;
  endtask

  task automatic cpu_rd(input logic [4:0] a, input logic [7:0] exp);
    cpu_AD = a; cpu_rw = 1'b1; cpu_cs = 1'b1;
    tick();
    cpu_cs = 1'b0;
    @(negedge clk);
    check("cpu_read", {24'd0, cpu_DO}, {24'd0, exp});
    tick();
  endtask

  // Entered at a negedge; returns at the negedge of the first VALID cycle.
  task automatic wait_valid();
    int i;
    i = 0;
    while (!vec_valid && i < 20) begin
      tick();
      @(negedge clk);
      i++;
    end
    check("valid_seen", {31'd0, vec_valid}, 32'd1);
  endtask

  task automatic do_ack(input int s);
    tick();
    vec_ack = 1'b1;
    tick();
    vec_ack = 1'b0;
    @(negedge clk);
    check("valid_drop", {31'd0, vec_valid}, 32'd0);
    check("pend_clear", {31'd0, pend[s]}, 32'd0);
  endtask

  task automatic run_vec(input int s, input logic [31:0] exp);
    int c0;
    tick();
    reqv = 4'b0001 << s;
    c0 = cyc;
    sb.push_back('{src: 2'(s), addr: exp, cyc: c0 + n_of(s) + 3});
    tick();
    reqv = 4'd0;
    @(negedge clk);
    check("pend_set", {31'd0, pend[s]}, 32'd1);
    for (int k = 0; k < n_of(s); k++) begin
      tick();
      @(negedge clk);
      check("fetch_cs", {31'd0, ps_cs}, 32'd1);
      check("fetch_rw", {31'd0, ps_rw}, 32'd1);
      check("fetch_ad", {27'd0, ps_AD}, {27'd0, base_of(s) + 5'(k)});
    end
    tick();
    @(negedge clk);
    check("last_cs", {31'd0, ps_cs}, 32'd0);
    wait_valid();
    do_ack(s);
  endtask

  logic [7:0] pre [16] = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33,
                           8'h44, 8'h01, 8'h02, 8'h03, 8'h04, 8'hDE, 8'hAD, 8'hBE};

  initial begin
    int c0, t, seen;
    // Reset state
    @(negedge clk);
    check("rst_pend", {28'd0, pend}, 32'd0);
    check("rst_valid", {31'd0, vec_valid}, 32'd0);
    check("rst_addr", vec_addr, 32'd0);
    check("rst_src", {30'd0, vec_src}, 32'd0);
    check("rst_wait", {31'd0, cpu_wait}, 32'd0);
    check("rst_cs", {31'd0, ps_cs}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) cpu_wr(5'h10 + 5'(i), pre[i]);
    cpu_rd(5'h13, 8'hBB);

    // IRQ, then NMI
    run_vec(0, 32'h00AABBCC);
    run_vec(2, 32'h01020304);

    // IRQ and NMI together: NMI first, IRQ follows without a new request
    tick();
    reqv = 4'b0101;
    c0 = cyc;
    sb.push_back('{src: 2'd2, addr: 32'h01020304, cyc: c0 + 7});
    tick();
    reqv = 4'd0;
    @(negedge clk);
    check("both_pend", {28'd0, pend}, 32'h5);
    wait_valid();
    tick();
    vec_ack = 1'b1;
    t = cyc;
    sb.push_back('{src: 2'd0, addr: 32'h00AABBCC, cyc: t + 6});
    tick();
    vec_ack = 1'b0;
    @(negedge clk);
    check("nmi_acked_pend", {28'd0, pend}, 32'h1);
    tick();
    @(negedge clk);
    check("irq_follow_cs", {31'd0, ps_cs}, 32'd1);
    check("irq_follow_ad", {27'd0, ps_AD}, 32'h12);
    wait_valid();
    do_ack(0);

    // CPU write held across a RES fetch
    tick();
    reqv = 4'b1000;
    c0 = cyc;
    sb.push_back('{src: 2'd3, addr: 32'h00DEADBE, cyc: c0 + 6});
    tick();
    reqv = 4'd0;
    tick();
    cpu_AD = 5'h10; cpu_DI = 8'h5A; cpu_rw = 1'b0; cpu_cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_wait", {31'd0, cpu_wait}, 32'd1);
      check("stall_rw", {31'd0, ps_rw}, 32'd1);
      tick();
    end
    @(negedge clk);
    check("fwd_wait", {31'd0, cpu_wait}, 32'd0);
    check("fwd_cs", {31'd0, ps_cs}, 32'd1);
    check("fwd_rw", {31'd0, ps_rw}, 32'd0);
    check("fwd_ad", {27'd0, ps_AD}, 32'h10);
    tick();
    cpu_cs = 1'b0; cpu_rw = 1'b1;
    @(negedge clk);
    do_ack(3);
    tick();
    cpu_rd(5'h10, 8'h5A);

    // Fetch deferred while the CPU holds cpu_cs in IDLE
    cpu_AD = 5'h11; cpu_rw = 1'b1; cpu_cs = 1'b1;
    reqv = 4'b0001;
    c0 = cyc;
    tick();
    reqv = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("defer_ad", {27'd0, ps_AD}, 32'h11);
      check("defer_wait", {31'd0, cpu_wait}, 32'd0);
      tick();
    end
    cpu_cs = 1'b0;
    sb.push_back('{src: 2'd0, addr: 32'h00AABBCC, cyc: c0 + 10});
    tick();
    @(negedge clk);
    check("defer_fetch_ad", {27'd0, ps_AD}, 32'h12);
    check("defer_fetch_cs", {31'd0, ps_cs}, 32'd1);
    wait_valid();
    do_ack(0);

    // Reset during the second FETCH cycle of SWI
    tick();
    reqv = 4'b0010;
    tick();
    reqv = 4'd0;
    tick();
    @(negedge clk);
    check("swi_fetch0_ad", {27'd0, ps_AD}, 32'h15);
    tick();
    rst = 1'b0;
    #1;
    check("arst_cs", {31'd0, ps_cs}, 32'd0);
    check("arst_pend", {28'd0, pend}, 32'd0);
    check("arst_valid", {31'd0, vec_valid}, 32'd0);
    check("arst_src", {30'd0, vec_src}, 32'd0);
    check("arst_addr", vec_addr, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (vec_valid || ps_cs) seen++;
    end
    check("quiet_after_rst", seen, 0);

    // req_swi coincident with SWI ack keeps pend and refetches
    tick();
    reqv = 4'b0010;
    c0 = cyc;
    sb.push_back('{src: 2'd1, addr: 32'h11223344, cyc: c0 + 7});
    tick();
    reqv = 4'd0;
    @(negedge clk);
    wait_valid();
    tick();
    vec_ack = 1'b1;
    reqv = 4'b0010;
    t = cyc;
    sb.push_back('{src: 2'd1, addr: 32'h11223344, cyc: t + 7});
    tick();
    vec_ack = 1'b0;
    reqv = 4'd0;
    @(negedge clk);
    check("coinc_valid", {31'd0, vec_valid}, 32'd0);
    check("coinc_pend", {28'd0, pend}, 32'h2);
    tick();
    @(negedge clk);
    check("refetch_cs", {31'd0, ps_cs}, 32'd1);
    check("refetch_ad", {27'd0, ps_AD}, 32'h15);
    wait_valid();
    do_ack(1);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vecfetch.md
# vecfetch

Interrupt-vector fetch sequencer and bus arbiter in front of the page/vector register block (registers $10–$1F). It shares that block's register bus between the CPU and an internal sequencer. On an IRQ, SWI, NMI or RESET request, it reads the corresponding vector bytes ($12/$15/$19/$1D) and presents the assembled address to the core with a valid/ack handshake. CPU accesses are forwarded unchanged, except that they stall while a fetch owns the bus.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_AD  in  5  CPU register address
- cpu_DI  in  8  CPU write data
- cpu_DO  out  8  CPU read data (= ps_DO, combinational)
- cpu_rw  in  1  1 = read, 0 = write
- cpu_cs  in  1  CPU select of register block
- cpu_wait  out  1  stall: CPU access not forwarded this cycle
- ps_AD  out  5  register-block address
- ps_DI  out  8  register-block write data (= cpu_DI)
- ps_DO  in  8  register-block read data; registered, valid the cycle after a read select
- ps_rw  out  1  register-block rw
- ps_cs  out  1  register-block select
- req_irq, req_swi, req_nmi, req_res  in  1 each  one-cycle request pulses
- pend  out  4  pending flags {res,nmi,swi,irq}
- vec_valid  out  1  vec_addr/vec_src valid
- vec_addr  out  32  fetched vector, first byte read = MSB of fetched bytes; 24-bit vectors zero-extended in [31:24]
- vec_src  out  2  0 IRQ, 1 SWI, 2 NMI, 3 RES
- vec_ack  in  1  consumer accepts vector

## Operation
- Vector map (base, byte count N): IRQ $12/3, SWI $15/4, NMI $19/4, RES $1D/3.
- Each req pulse sets its sticky pend bit on the next edge. A pulse for an already-pending source is absorbed.
- Priority when selecting: RES > NMI > SWI > IRQ. A fetch in progress is never preempted. A higher-priority request is served at the next IDLE.
- IDLE:
  - Forward the CPU: ps_AD=cpu_AD, ps_rw=cpu_rw, ps_cs=cpu_cs, cpu_wait=0.
  - If pend≠0 and cpu_cs=0: latch the selected source into vec_src, clear vec_addr, go to FETCH with index k=0.
  - If cpu_cs=1: the CPU wins and the sequencer waits. Continuous CPU selects starve the sequencer by design.
- FETCH (N cycles):
  - ps_cs=1, ps_rw=1, ps_AD=base+k; k increments each cycle.
  - Leave for LAST after k=N−1.
- LAST (1 cycle): ps_cs=0; captures the final byte.
- Byte capture: a registered "issued" flag marks a read issued in the previous cycle. When set, vec_addr <= {vec_addr[23:0], ps_DO}.
- VALID: vec_valid=1; vec_addr and vec_src held stable. The CPU is forwarded as in IDLE.
  - On vec_ack: clear pend[vec_src], vec_valid=0, return to IDLE.
  - If a req pulse for the same source coincides with vec_ack, the pulse wins and pend stays set.
  - A req pulse for the same source arriving during FETCH, LAST or VALID (not at ack) is merged and cleared at ack.
- FETCH and LAST:
  - cpu_wait = cpu_cs (combinational).
  - The CPU access is not forwarded; the CPU must hold its signals until cpu_wait drops.
  - The sequencer never writes: ps_rw=1 throughout.
- vec_ack outside VALID is ignored.

## Timing
- Reset (rst low, asynchronous): state IDLE, pend=0, vec_valid=0, vec_addr=0, vec_src=0, issued flag=0. Bus outputs revert immediately to CPU passthrough.
- Reset mid-fetch aborts with no further ps_cs from the sequencer. Partial data is discarded.
- Request pulse in cycle 0 with bus free:
  - pend set at end of cycle 0, IDLE decides in cycle 1.
  - FETCH in cycles 2..N+1, LAST in cycle N+2.
  - vec_valid rises in cycle N+3: 6 for IRQ/RES, 7 for SWI/NMI.
- ack in cycle t: vec_valid low in t+1; earliest next FETCH cycle is t+2.
- cpu_wait is combinational from cpu_cs and state. The CPU access proceeds in the first IDLE/VALID cycle.

## Test plan
- IRQ with $12–$14 preloaded AA,BB,CC; req_irq pulse cycle 0 → ps_AD 12,13,14 in cycles 2–4, vec_valid cycle 6, vec_addr=00AABBCC, vec_src=0; ack → pend[0]=0.
- NMI with $19–$1C = 01,02,03,04 → four reads; vec_addr=01020304, vec_src=2, valid at cycle 7.
- req_irq and req_nmi pulsed in the same cycle → NMI served first; IRQ served after NMI ack with no extra request.
- cpu_cs held during FETCH → cpu_wait=1 and no CPU select reaches ps_cs. Write to $10 completes in the cycle after LAST. With cpu_cs high in IDLE, the fetch is deferred until cpu_cs drops.
- rst low during the second FETCH cycle of SWI → all outputs reset at once, pend=0. No vec_valid after release until a new request.
- req_swi coincident with SWI vec_ack → pend[1] remains 1 and a second SWI fetch starts two cycles later.
